mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Streams a host FIFO (first-word-fall-through) into the instruction, weight
// and XY memories, and launches the controller on a RUN command.
//
// Command stream: header, base address, count, payload.
//   header[15:14] : target (00 INST, 01 W, 10 XY, 11 RUN; RUN has no body)
//   header[13:10] : neuron-unit index (W only)
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   buffer_empty/data    : FIFO head, data valid while buffer_empty is low
//   buffer_read_enable   : pops the head word
//   inst_write_*         : instruction memory write (INST_WORDS words/write)
//   w_write_*            : weight memory write, one-hot enable per unit
//   mm_xy_write_*        : XY memory write
//   start / done         : controller launch pulse / completion
//   busy                 : high outside HEADER
//   error                : sticky, set by a W command for a missing unit
// ---------------------------------------------------------------------------
module mem_loader #(
   parameter int DATA_WIDTH     = 16,
   parameter int INST_WORDS     = 4,
   parameter int INST_MEM_DEPTH = 8,
   parameter int W_MEM_DEPTH    = 10,
   parameter int XY_MEM_DEPTH   = 10,
   parameter int NU_COUNT       = 4,
   localparam int INST_MEM_SIZE = INST_WORDS * DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      buffer_empty,
   input  logic [DATA_WIDTH-1:0]     buffer_data,
   output logic                      buffer_read_enable,
   output logic                      inst_write_enable,
   output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
   output logic [INST_MEM_SIZE-1:0]  inst_write_data,
   output logic [NU_COUNT-1:0]       w_write_enable,
   output logic [W_MEM_DEPTH-1:0]    w_write_addr,
   output logic [DATA_WIDTH-1:0]     w_write_data,
   output logic                      mm_xy_write_enable,
   output logic [XY_MEM_DEPTH:0]     mm_xy_write_addr,
   output logic [DATA_WIDTH-1:0]     mm_xy_write_data,
   output logic                      start,
   input  logic                      done,
   output logic                      busy,
   output logic                      error
);

   typedef enum logic [2:0] {
      HEADER    = 3'd0,
      ADDR      = 3'd1,
      COUNT     = 3'd2,
      DATA      = 3'd3,
      RUN       = 3'd4,
      WAIT_DONE = 3'd5
   } state_t;

   localparam logic [1:0] T_INST = 2'b00;
   localparam logic [1:0] T_W    = 2'b01;
   localparam logic [1:0] T_RUN  = 2'b11;

   localparam int WI_W = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
   localparam logic [WI_W-1:0] LAST_IDX = WI_W'(INST_WORDS - 1);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   // Address masks; the XY port is one bit wider than XY_MEM_DEPTH.
   localparam logic [DATA_WIDTH-1:0] INST_MASK = DATA_WIDTH'((64'd1 << INST_MEM_DEPTH) - 64'd1);
   localparam logic [DATA_WIDTH-1:0] W_MASK    = DATA_WIDTH'((64'd1 << W_MEM_DEPTH) - 64'd1);
   localparam logic [DATA_WIDTH-1:0] XY_MASK   = DATA_WIDTH'((64'd1 << (XY_MEM_DEPTH + 1)) - 64'd1);

   function automatic logic [DATA_WIDTH-1:0] depth_mask(input logic [1:0] tgt);
      case (tgt)
         T_INST:  depth_mask = INST_MASK;
         T_W:     depth_mask = W_MASK;
         default: depth_mask = XY_MASK;
      endcase
   endfunction

   state_t                    state_r;
   logic [1:0]                target_r;
   logic [3:0]                nu_idx_r;
   logic                      nu_ok_r;
   logic [DATA_WIDTH-1:0]     addr_r;
   logic [DATA_WIDTH-1:0]     count_r;
   logic [WI_W-1:0]           word_idx_r;
   logic [INST_MEM_SIZE-1:0]  asm_r;

   logic                      pop_s;
   logic                      last_s;
   logic [INST_MEM_SIZE-1:0]  asm_next_s;
   logic [DATA_WIDTH-1:0]     addr_next_s;

   // Pop decode, instruction assembly, address wrap and end-of-payload detect.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         HEADER, ADDR, COUNT, DATA: pop_s = !buffer_empty;
         default:                   pop_s = 1'b0;
      endcase
      // New word enters at the top, so the first word ends up in the low bits.
      asm_next_s  = INST_MEM_SIZE'({buffer_data, asm_r} >> DATA_WIDTH);
      addr_next_s = (addr_r + ONE) & depth_mask(target_r);
      if (target_r == T_INST) begin
         last_s = (word_idx_r == LAST_IDX) && (count_r == ONE);
      end else begin
         last_s = (count_r == ONE);
      end
   end

   assign buffer_read_enable = pop_s;

   // Command FSM with registered write ports, start pulse, busy and error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r            <= HEADER;
         target_r           <= 2'b00;
         nu_idx_r           <= 4'd0;
         nu_ok_r            <= 1'b0;
         addr_r             <= '0;
         count_r            <= '0;
         word_idx_r         <= '0;
         asm_r              <= '0;
         inst_write_enable  <= 1'b0;
         inst_write_addr    <= '0;
         inst_write_data    <= '0;
         w_write_enable     <= '0;
         w_write_addr       <= '0;
         w_write_data       <= '0;
         mm_xy_write_enable <= 1'b0;
         mm_xy_write_addr   <= '0;
         mm_xy_write_data   <= '0;
         start              <= 1'b0;
         busy               <= 1'b0;
         error              <= 1'b0;
      end else begin
         inst_write_enable  <= 1'b0;
         w_write_enable     <= '0;
         mm_xy_write_enable <= 1'b0;
         start              <= 1'b0;
         case (state_r)
            HEADER: begin
               if (pop_s) begin
                  busy <= 1'b1;
                  if (buffer_data[15:14] == T_RUN) begin
                     start   <= 1'b1;
                     state_r <= RUN;
                  end else begin
                     target_r <= buffer_data[15:14];
                     nu_idx_r <= buffer_data[13:10];
                     nu_ok_r  <= int'(buffer_data[13:10]) < NU_COUNT;
                     if ((buffer_data[15:14] == T_W) && (int'(buffer_data[13:10]) >= NU_COUNT)) begin
                        error <= 1'b1;
                     end
                     state_r <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (pop_s) begin
                  addr_r  <= buffer_data & depth_mask(target_r);
                  state_r <= COUNT;
               end
            end
            COUNT: begin
               if (pop_s) begin
                  count_r    <= buffer_data;
                  word_idx_r <= '0;
                  asm_r      <= '0;
                  if (buffer_data == '0) begin
                     busy    <= 1'b0;
                     state_r <= HEADER;
                  end else begin
                     state_r <= DATA;
                  end
               end
            end
            DATA: begin
               if (pop_s) begin
                  case (target_r)
                     T_INST: begin
                        asm_r <= asm_next_s;
                        if (word_idx_r == LAST_IDX) begin
                           inst_write_enable <= 1'b1;
                           inst_write_addr   <= addr_r[INST_MEM_DEPTH-1:0];
                           inst_write_data   <= asm_next_s;
                           addr_r            <= addr_next_s;
                           word_idx_r        <= '0;
                           count_r           <= count_r - ONE;
                        end else begin
                           word_idx_r <= word_idx_r + WI_W'(1);
                        end
                     end
                     T_W: begin
                        // A missing unit still drains its payload, silently.
                        if (nu_ok_r) begin
                           w_write_enable <= NU_COUNT'(1'b1) << nu_idx_r;
                        end
                        w_write_addr <= addr_r[W_MEM_DEPTH-1:0];
                        w_write_data <= buffer_data;
                        addr_r       <= addr_next_s;
                        count_r      <= count_r - ONE;
                     end
                     default: begin
                        mm_xy_write_enable <= 1'b1;
                        mm_xy_write_addr   <= addr_r[XY_MEM_DEPTH:0];
                        mm_xy_write_data   <= buffer_data;
                        addr_r             <= addr_next_s;
                        count_r            <= count_r - ONE;
                     end
                  endcase
                  if (last_s) begin
                     busy    <= 1'b0;
                     state_r <= HEADER;
                  end
               end
            end
            RUN: begin
               state_r <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done) begin
                  busy    <= 1'b0;
                  state_r <= HEADER;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= HEADER;
            end
         endcase
      end
   end

endmodule
